// File: rtl/bus_cycle_sequencer_if.sv
// CPU-side bus bundle for the chip-select sequencer: request inputs plus
// the four active-low chip enables, ACK and WP_ERR pulses.
interface bus_cycle_sequencer_if;
  logic [15:13] ADDR;
  logic         RW;
  logic         VALID;
  logic         EEPROM_CE_N;
  logic         RAM_CE_N;
  logic         VIA_CE_N;
  logic         ACIA_CE_N;
  logic         ACK;
  logic         WP_ERR;

  modport slave (
    input  ADDR, RW, VALID,
    output EEPROM_CE_N, RAM_CE_N, VIA_CE_N, ACIA_CE_N, ACK, WP_ERR
  );

  modport master (
    output ADDR, RW, VALID,
    input  EEPROM_CE_N, RAM_CE_N, VIA_CE_N, ACIA_CE_N, ACK, WP_ERR
  );
endinterface

// File: rtl/bus_cycle_sequencer.sv
// Chip-select sequencer: decodes ADDR[15:13], stretches the selected CE_N for a
// per-device wait count, then pulses ACK. Optional macro EEPROM_WP_EN blocks EEPROM writes.
module bus_cycle_sequencer #(
  parameter int RAM_WAIT    = 0,
  parameter int VIA_WAIT    = 1,
  parameter int ACIA_WAIT   = 2,
  parameter int EEPROM_WAIT = 3,
  parameter int CNT_W       = 4
) (
  input logic                  CLK,
  input logic                  RESET,
  bus_cycle_sequencer_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;
  localparam logic [1:0] ST_WPERR  = 2'd3;

  localparam logic [1:0] RG_RAM    = 2'd0;
  localparam logic [1:0] RG_VIA    = 2'd1;
  localparam logic [1:0] RG_ACIA   = 2'd2;
  localparam logic [1:0] RG_EEPROM = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [1:0]       region_q, region_d;
  logic [1:0]       addr_region;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] wait_sel;
  logic [3:0]       ce_n_q, ce_n_d;
  logic             ack_q, ack_d;
  logic             wp_block;

  always_comb begin
    case (bus.ADDR)
      3'b100:         addr_region = RG_VIA;
      3'b101:         addr_region = RG_ACIA;
      3'b110, 3'b111: addr_region = RG_EEPROM;
      default:        addr_region = RG_RAM;
    endcase
  end

  always_comb begin
    case (addr_region)
      RG_VIA:    wait_sel = CNT_W'(VIA_WAIT);
      RG_ACIA:   wait_sel = CNT_W'(ACIA_WAIT);
      RG_EEPROM: wait_sel = CNT_W'(EEPROM_WAIT);
      default:   wait_sel = CNT_W'(RAM_WAIT);
    endcase
  end

`ifdef EEPROM_WP_EN
  assign wp_block = !bus.RW && (addr_region == RG_EEPROM);
`else
  assign wp_block = 1'b0;
`endif

  // Abort (VALID dropped) takes priority over wait expiry while in ACCESS.
  always_comb begin
    state_d  = state_q;
    region_d = region_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.VALID) begin
          region_d = addr_region;
          if (wp_block) begin
            state_d = ST_WPERR;
          end else begin
            cnt_d   = wait_sel;
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (!bus.VALID) begin
          state_d = ST_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    ce_n_d = 4'b1111;
    if ((state_d == ST_ACCESS) || (state_d == ST_DONE)) begin
      ce_n_d[region_d] = 1'b0;
    end
    ack_d = (state_d == ST_DONE) || (state_d == ST_WPERR);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      region_q <= RG_RAM;
      cnt_q    <= '0;
      ce_n_q   <= 4'b1111;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      cnt_q    <= cnt_d;
      ce_n_q   <= ce_n_d;
      ack_q    <= ack_d;
    end
  end

`ifdef EEPROM_WP_EN
  logic wp_err_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wp_err_q <= 1'b0;
    end else begin
      wp_err_q <= (state_d == ST_WPERR);
    end
  end

  assign bus.WP_ERR = wp_err_q;
`else
  assign bus.WP_ERR = 1'b0;
`endif

  assign bus.RAM_CE_N    = ce_n_q[RG_RAM];
  assign bus.VIA_CE_N    = ce_n_q[RG_VIA];
  assign bus.ACIA_CE_N   = ce_n_q[RG_ACIA];
  assign bus.EEPROM_CE_N = ce_n_q[RG_EEPROM];
  assign bus.ACK         = ack_q;

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Self-checking bench for bus_cycle_sequencer: cycle-level behavioural model
// plus directed and randomized CPU bus requests.
module tb_bus_cycle_sequencer;

  logic CLK;
  logic RESET;

  bus_cycle_sequencer_if busIf();

  bus_cycle_sequencer dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (busIf)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int passes = 0;

  // Behavioural model: an access that starts at an edge occupies output cycles
  // 1..W+2 (CE low), with ACK in cycle W+2; region index 0=RAM,1=VIA,2=ACIA,3=EEPROM.
  logic [5:0] expVec = 6'b111100;
  bit mBusy = 0;
  bit mWp   = 0;
  int mK    = 0;
  int mW    = 0;
  int mReg  = 0;

  function automatic int regionOf(input logic [2:0] a);
    if (a < 3'd4) return 0;
    if (a == 3'd4) return 1;
    if (a == 3'd5) return 2;
    return 3;
  endfunction

  function automatic int waitOf(input int r);
    case (r)
      1:       return 1;
      2:       return 2;
      3:       return 3;
      default: return 0;
    endcase
  endfunction

  always @(posedge CLK) begin
    bit blockWrite;
    logic [3:0] ce;
    if (RESET) begin
      mBusy = 0;
      mWp   = 0;
    end else if (mWp) begin
      mWp = 0;
    end else if (mBusy) begin
      if (mK == mW + 2) mBusy = 0;
      else if (!busIf.VALID) mBusy = 0;
      else mK++;
    end else if (busIf.VALID) begin
      mReg = regionOf(busIf.ADDR);
      blockWrite = 0;
`ifdef EEPROM_WP_EN
      blockWrite = (mReg == 3) && !busIf.RW;
`endif
      if (blockWrite) begin
        mWp = 1;
      end else begin
        mBusy = 1;
        mK    = 1;
        mW    = waitOf(mReg);
      end
    end
    ce = 4'b1111;
    if (mBusy) ce[mReg] = 1'b0;
    expVec = {ce[3], ce[0], ce[1], ce[2], (mBusy && mK == mW + 2) || mWp, mWp};
  end

  int lowCnt[4];
  int ackCnt, wpCnt, cycleNo, firstAck, lastAck;
  logic [5:0] actVec;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycleNo);
  endtask

  task automatic applyStimulus(input logic rst, input logic valid, input logic [2:0] addr, input logic rw);
    RESET       = rst;
    busIf.VALID = valid;
    busIf.ADDR  = addr;
    busIf.RW    = rw;
  endtask

  task automatic clearTally();
    for (int i = 0; i < 4; i++) lowCnt[i] = 0;
    ackCnt = 0;
    wpCnt  = 0;
  endtask

  // One clock: compare every output against the model on the falling edge.
  task automatic tick();
    @(negedge CLK);
    cycleNo++;
    actVec = {busIf.EEPROM_CE_N, busIf.RAM_CE_N, busIf.VIA_CE_N, busIf.ACIA_CE_N, busIf.ACK, busIf.WP_ERR};
    checkOutput("cycleOutputs", int'(actVec), int'(expVec));
    if (!busIf.RAM_CE_N)    lowCnt[0]++;
    if (!busIf.VIA_CE_N)    lowCnt[1]++;
    if (!busIf.ACIA_CE_N)   lowCnt[2]++;
    if (!busIf.EEPROM_CE_N) lowCnt[3]++;
    if (busIf.WP_ERR) wpCnt++;
    if (busIf.ACK) begin
      ackCnt++;
      if (ackCnt == 1) firstAck = cycleNo;
      lastAck = cycleNo;
    end
  endtask

  task automatic doAccess(input logic [2:0] addr, input logic rw, input bit hold);
    clearTally();
    applyStimulus(1'b0, 1'b1, addr, rw);
    for (int i = 0; i < 30 && ackCnt == 0; i++) tick();
    if (ackCnt == 0) checkOutput("ackTimeout", 0, 1);
    if (!hold) begin
      busIf.VALID = 1'b0;
      tick();
    end
  endtask

  int expLow[8] = '{2, 2, 2, 2, 3, 4, 5, 5};

  initial begin
    int startCycle, kind, limit;
    cycleNo = 0;
    clearTally();
    applyStimulus(1'b1, 1'b0, 3'b000, 1'b1);
    tick();
    tick();
    actVec = {busIf.EEPROM_CE_N, busIf.RAM_CE_N, busIf.VIA_CE_N, busIf.ACIA_CE_N, busIf.ACK, busIf.WP_ERR};
    checkOutput("resetState", int'(actVec), 32'h3C);

    doAccess(3'b010, 1'b1, 0);
    checkOutput("ramReadCeCycles", lowCnt[0], 2);
    checkOutput("ramReadOthersLow", lowCnt[1] + lowCnt[2] + lowCnt[3], 0);
    checkOutput("ramReadAcks", ackCnt, 1);

    for (int a = 0; a < 8; a++) begin
      doAccess(3'(a), 1'b1, 0);
      checkOutput($sformatf("sweepCe%0d", a), lowCnt[regionOf(3'(a))], expLow[a]);
      checkOutput($sformatf("sweepTotal%0d", a), lowCnt[0] + lowCnt[1] + lowCnt[2] + lowCnt[3], expLow[a]);
      checkOutput($sformatf("sweepAck%0d", a), ackCnt, 1);
    end

    clearTally();
    applyStimulus(1'b0, 1'b1, 3'b101, 1'b1);
    for (int i = 0; i < 40 && ackCnt < 2; i++) tick();
    checkOutput("b2bAcks", ackCnt, 2);
    checkOutput("b2bAckSpacing", lastAck - firstAck, 5);
    checkOutput("b2bAciaLow", lowCnt[2], 8);
    busIf.VALID = 1'b0;
    tick();

    clearTally();
    applyStimulus(1'b0, 1'b1, 3'b110, 1'b1);
    tick();
    tick();
    busIf.VALID = 1'b0;
    tick();
    checkOutput("abortCeHigh", int'(busIf.EEPROM_CE_N), 1);
    repeat (3) tick();
    checkOutput("abortNoAck", ackCnt, 0);
    doAccess(3'b001, 1'b1, 0);
    checkOutput("postAbortRam", lowCnt[0], 2);

    clearTally();
    applyStimulus(1'b0, 1'b1, 3'b111, 1'b1);
    repeat (3) tick();
    RESET = 1'b1;
    tick();
    actVec = {busIf.EEPROM_CE_N, busIf.RAM_CE_N, busIf.VIA_CE_N, busIf.ACIA_CE_N, busIf.ACK, busIf.WP_ERR};
    checkOutput("midResetIdle", int'(actVec), 32'h3C);
    RESET = 1'b0;
    tick();
    checkOutput("restartCeLow", int'(busIf.EEPROM_CE_N), 0);
    for (int i = 0; i < 30 && ackCnt == 0; i++) tick();
    checkOutput("restartAck", ackCnt, 1);
    busIf.VALID = 1'b0;
    tick();

    startCycle = cycleNo;
    doAccess(3'b111, 1'b0, 0);
`ifdef EEPROM_WP_EN
    checkOutput("eepromWriteCe", lowCnt[3], 0);
    checkOutput("eepromWriteWpErr", wpCnt, 1);
    checkOutput("eepromWriteAckLat", firstAck - startCycle, 1);
`else
    checkOutput("eepromWriteCe", lowCnt[3], 5);
    checkOutput("eepromWriteWpErr", wpCnt, 0);
    checkOutput("eepromWriteAckLat", firstAck - startCycle, 5);
`endif

    for (int n = 0; n < 250; n++) begin
      kind = $urandom_range(0, 9);
      if (kind == 9) begin
        applyStimulus(1'b0, 1'b0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        repeat ($urandom_range(1, 3)) tick();
      end else begin
        clearTally();
        applyStimulus(1'b0, 1'b1, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        limit = (kind < 6) ? 30 : $urandom_range(1, 4);
        for (int i = 0; i < limit && ackCnt == 0; i++) begin
          tick();
          busIf.ADDR = 3'($urandom_range(0, 7));
          busIf.RW   = 1'($urandom_range(0, 1));
        end
        if (kind < 6 && ackCnt == 0) checkOutput("randAckTimeout", 0, 1);
        if (kind >= 6) busIf.VALID = 1'b0;
        if (kind == 8) begin
          RESET = 1'b1;
          tick();
          RESET = 1'b0;
        end
        if ($urandom_range(0, 3) != 0) begin
          busIf.VALID = 1'b0;
          tick();
        end
      end
    end

    busIf.VALID = 1'b0;
    repeat (4) tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
